fc8_palette_dac: RTL

- Final video stage of the FC8 graphics path. Sits directly downstream of fc8_sprite_engine.
- Converts the 8-bit mixed colour index (sprite engine final_pixel_color_out) into RGB565 through a 256-entry CPU-writable palette RAM.
- Delays sync and data-enable so they stay aligned with colour.
- Provides the CPU palette port (SFR-mapped, auto-incrementing) and a border colour for non-active video.

---
 rtl/fc8_palette_dac.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/fc8_palette_dac.sv
`default_nettype none
// ============================================================================
// Module   : fc8_palette_dac
// Purpose  : Final FC8 video stage. Maps the 8-bit mixed colour index to
//            RGB565 through a 256x16 CPU-writable palette, delays sync/DE to
//            stay aligned with colour, and supplies a border colour outside
//            active video. The palette is zeroed after every reset.
// Revision : 1.0 - initial release
// ============================================================================
module fc8_palette_dac #(
    parameter int PAL_ENTRIES = 256,
    parameter int PIPE_LAT    = 2
) (
    input  logic       clk_pixel,
    input  logic       rst,
    input  logic [7:0] pixel_index_in,
    input  logic       active_video_in,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       sfr_wr_en,
    input  logic       sfr_rd_en,
    input  logic [1:0] sfr_addr,
    input  logic [7:0] sfr_wdata,
    output logic [7:0] sfr_rdata,
    output logic [4:0] rgb_r_out,
    output logic [5:0] rgb_g_out,
    output logic [4:0] rgb_b_out,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       de_out
);

    localparam logic [7:0] C_LAST_ENTRY = 8'(PAL_ENTRIES - 1);

    localparam logic [1:0] C_REG_ADDR   = 2'd0;
    localparam logic [1:0] C_REG_DATA   = 2'd1;
    localparam logic [1:0] C_REG_CTRL   = 2'd2;
    localparam logic [1:0] C_REG_BORDER = 2'd3;

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_clearing;
    logic [7:0]  r_clr_cnt;

    // CPU-visible registers
    logic [7:0]  r_pal_index;
    logic        r_byte_phase;
    logic [7:0]  r_lo_hold;
    logic [7:0]  r_border_idx;
    logic        r_border_en;
    logic [7:0]  r_rdata;

    // Palette storage and its single write port
    logic [15:0] r_pal [PAL_ENTRIES];
    logic        w_pal_we;
    logic [7:0]  w_pal_waddr;
    logic [15:0] w_pal_wdata;
    logic [15:0] w_cpu_word;
    logic        w_data_wr;

    // Video pipe
    logic [7:0]          r_rd_addr;
    logic                r_show1;
    logic [15:0]         r_rgb;
    logic [PIPE_LAT-1:0] r_hs_pipe;
    logic [PIPE_LAT-1:0] r_vs_pipe;
    logic [PIPE_LAT-1:0] r_de_pipe;

    assign w_clearing = (r_state == S_CLEAR);
    assign w_data_wr  = sfr_wr_en && (sfr_addr == C_REG_DATA);
    // CPU reads share the write-port address so video reads never stall
    assign w_cpu_word = r_pal[r_pal_index];

    // State register for the clear / run sequencer
    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: leave the clear once the last entry has been written
    always_comb begin
        w_state_next = r_state;
        if ((r_state == S_CLEAR) && (r_clr_cnt == C_LAST_ENTRY)) begin
            w_state_next = S_RUN;
        end
    end

    // Clear address counter; restarts at entry 0 on every reset
    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            r_clr_cnt <= 8'd0;
        end else if (w_clearing) begin
            r_clr_cnt <= r_clr_cnt + 8'd1;
        end
    end

    // Write-port mux: clear sequencer owns the port, otherwise CPU high-byte writes
    always_comb begin
        w_pal_we    = 1'b0;
        w_pal_waddr = r_pal_index;
        w_pal_wdata = {sfr_wdata, r_lo_hold};
        if (!rst) begin
            if (w_clearing) begin
                w_pal_we    = 1'b1;
                w_pal_waddr = r_clr_cnt;
                w_pal_wdata = 16'h0000;
            end else if (w_data_wr && r_byte_phase) begin
                w_pal_we = 1'b1;
            end
        end
    end

    // Palette RAM; same-cycle video read returns the old word
    always_ff @(posedge clk_pixel) begin
        if (w_pal_we) begin
            r_pal[w_pal_waddr] <= w_pal_wdata;
        end
    end

    // SFR block: writes win over a simultaneous read, which is then dropped
    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            r_pal_index  <= 8'd0;
            r_byte_phase <= 1'b0;
            r_lo_hold    <= 8'd0;
            r_border_idx <= 8'd0;
            r_border_en  <= 1'b0;
            r_rdata      <= 8'd0;
        end else if (sfr_wr_en) begin
            case (sfr_addr)
                C_REG_ADDR: begin
                    r_pal_index  <= sfr_wdata;
                    r_byte_phase <= 1'b0;
                end
                C_REG_DATA: begin
                    if (!w_clearing) begin
                        if (!r_byte_phase) begin
                            r_lo_hold    <= sfr_wdata;
                            r_byte_phase <= 1'b1;
                        end else begin
                            r_pal_index  <= r_pal_index + 8'd1;
                            r_byte_phase <= 1'b0;
                        end
                    end
                end
                C_REG_CTRL: begin
                    r_border_en <= sfr_wdata[0];
                end
                C_REG_BORDER: begin
                    r_border_idx <= sfr_wdata;
                end
                default: ;
            endcase
        end else if (sfr_rd_en) begin
            case (sfr_addr)
                C_REG_ADDR: begin
                    r_rdata <= r_pal_index;
                end
                C_REG_DATA: begin
                    r_rdata      <= r_byte_phase ? w_cpu_word[15:8] : w_cpu_word[7:0];
                    r_byte_phase <= ~r_byte_phase;
                    if (r_byte_phase) begin
                        r_pal_index <= r_pal_index + 8'd1;
                    end
                end
                C_REG_CTRL: begin
                    r_rdata <= {w_clearing, 5'b00000, r_byte_phase, r_border_en};
                end
                C_REG_BORDER: begin
                    r_rdata <= r_border_idx;
                end
                default: ;
            endcase
        end
    end

    // Stage 1: select the palette address (pixel or border) and whether to show it
    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            r_rd_addr <= 8'd0;
            r_show1   <= 1'b0;
        end else begin
            r_show1 <= active_video_in | r_border_en;
            if (active_video_in) begin
                r_rd_addr <= pixel_index_in;
            end else if (r_border_en) begin
                r_rd_addr <= r_border_idx;
            end
        end
    end

    // Stage 2: register colour; blanked during the clear and outside shown pixels
    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            r_rgb <= 16'h0000;
        end else if (w_clearing || !r_show1) begin
            r_rgb <= 16'h0000;
        end else begin
            r_rgb <= r_pal[r_rd_addr];
        end
    end

    // Timing pipes keep sync and DE aligned with the colour stages
    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            r_hs_pipe <= '0;
            r_vs_pipe <= '0;
            r_de_pipe <= '0;
        end else begin
            r_hs_pipe <= {r_hs_pipe[PIPE_LAT-2:0], hsync_in};
            r_vs_pipe <= {r_vs_pipe[PIPE_LAT-2:0], vsync_in};
            r_de_pipe <= {r_de_pipe[PIPE_LAT-2:0], active_video_in};
        end
    end

    assign sfr_rdata = r_rdata;
    assign rgb_r_out = r_rgb[15:11];
    assign rgb_g_out = r_rgb[10:5];
    assign rgb_b_out = r_rgb[4:0];
    assign hsync_out = r_hs_pipe[PIPE_LAT-1];
    assign vsync_out = r_vs_pipe[PIPE_LAT-1];
    assign de_out    = r_de_pipe[PIPE_LAT-1];

endmodule
`default_nettype wire
